// File: rtl/register_file.sv
// MIPS 32x32 register file: two combinational read ports, one synchronous write port.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module register_file #(
    parameter logic [31:0] SP_RESET = 32'h7FFF_EFFC,
    parameter logic [31:0] GP_RESET = 32'h1000_8000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [4:0]  read_register1,
    input  logic [4:0]  read_register2,
    input  logic [4:0]  write_register,
    input  logic [31:0] write_data,
    input  logic        reg_write,
    output logic [31:0] read_data1,
    output logic [31:0] read_data2
);

    logic [31:0] regs_q [31:1];
    logic [31:0] regs_d [31:1];
    logic        wr_en;

    assign wr_en = reg_write && (write_register != 5'd0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[write_register] = write_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i < 32; i++) begin
                if (i == 28) begin
                    regs_q[i] <= GP_RESET;
                end else if (i == 29) begin
                    regs_q[i] <= SP_RESET;
                end else begin
                    regs_q[i] <= 32'h0;
                end
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // $zero has no storage; address 0 is decoded to a constant
    always_comb begin
        read_data1 = 32'h0;
        if (read_register1 != 5'd0) begin
            read_data1 = regs_q[read_register1];
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (write_register == read_register1)) begin
            read_data1 = write_data;
        end
`endif
    end

    always_comb begin
        read_data2 = 32'h0;
        if (read_register2 != 5'd0) begin
            read_data2 = regs_q[read_register2];
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (write_register == read_register2)) begin
            read_data2 = write_data;
        end
`endif
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus random traffic
// checked against an array model of the architectural registers.
module tb_register_file;

    localparam logic [31:0] SP_RST = 32'h7FFF_EFFC;
    localparam logic [31:0] GP_RST = 32'h1000_8000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  read_register1 = 5'd0;
    logic [4:0]  read_register2 = 5'd0;
    logic [4:0]  write_register = 5'd0;
    logic [31:0] write_data = 32'h0;
    logic        reg_write = 1'b0;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    int checks = 0;
    int failures = 0;
    logic [31:0] mdl [32];

    register_file #(
        .SP_RESET(SP_RST),
        .GP_RESET(GP_RST)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .read_register1(read_register1),
        .read_register2(read_register2),
        .write_register(write_register),
        .write_data(write_data),
        .reg_write(reg_write),
        .read_data1(read_data1),
        .read_data2(read_data2)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (reg_write === 1'b1) begin
            assert (!$isunknown(write_register)) else begin
                failures++;
                $error("FAIL wr_addr_x: write_register=%b with reg_write=1", write_register);
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        mdl[28] = GP_RST;
        mdl[29] = SP_RST;
    endtask

    // Expected value seen on a read port given the stored state and pending write
    function automatic logic [31:0] expect_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (reg_write && write_register != 5'd0 && write_register == a)
            return write_data;
`endif
        return mdl[a];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_both(input string tag);
        check({tag, "_rd1"}, read_data1, expect_rd(read_register1));
        check({tag, "_rd2"}, read_data2, expect_rd(read_register2));
    endtask

    // Present inputs just after a rising edge, check before the next edge,
    // then commit the write into the model at the edge.
    task automatic step(input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] ra1,
                        input logic [4:0] ra2, input string tag);
        reg_write = we;
        write_register = wa;
        write_data = wd;
        read_register1 = ra1;
        read_register2 = ra2;
        #2;
        check_both(tag);
        @(posedge clock);
        if (we && wa != 5'd0) mdl[wa] = wd;
        #1;
    endtask

    initial begin
        model_reset();
        #12;
        read_register1 = 5'd29;
        read_register2 = 5'd28;
        #1;
        check("in_reset_r29", read_data1, SP_RST);
        check("in_reset_r28", read_data2, GP_RST);
        #4 reset_n = 1'b1;
        @(posedge clock);
        #1;

        for (int a = 0; a < 32; a++) begin
            read_register1 = a[4:0];
            read_register2 = 5'(31 - a);
            #1;
            check("reset_scan_rd1", read_data1,
                  a == 28 ? GP_RST : a == 29 ? SP_RST : 32'h0);
            check("reset_scan_rd2", read_data2,
                  (31 - a) == 28 ? GP_RST : (31 - a) == 29 ? SP_RST : 32'h0);
        end

        step(1'b1, 5'd8, 32'hDEAD_BEEF, 5'd0, 5'd0, "wr_r8");
        step(1'b1, 5'd9, 32'h0000_0001, 5'd8, 5'd9, "wr_r9");
        step(1'b0, 5'd0, 32'h0, 5'd8, 5'd9, "rd_r8_r9");
        check("basic_r8", read_data1, 32'hDEAD_BEEF);
        check("basic_r9", read_data2, 32'h0000_0001);
        step(1'b0, 5'd0, 32'h0, 5'd8, 5'd8, "rd_r8_both");
        check("same_rd1", read_data1, 32'hDEAD_BEEF);
        check("same_rd2", read_data2, 32'hDEAD_BEEF);

        step(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, "wr_r0");
        step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, "rd_r0");
        check("zero_r0", read_data1, 32'h0);

        for (int c = 0; c < 3; c++)
            step(1'b0, 5'd5, 32'h1234_5678, 5'd5, 5'd5, "gate_r5");
        check("gate_r5_final", read_data1, 32'h0);

        step(1'b1, 5'd10, 32'h1, 5'd0, 5'd0, "wr_r10_old");
        reg_write = 1'b1;
        write_register = 5'd10;
        write_data = 32'h2;
        read_register1 = 5'd10;
        read_register2 = 5'd0;
        #2;
`ifdef REGFILE_BYPASS_EN
        check("rdw_before_edge", read_data1, 32'h2);
`else
        check("rdw_before_edge", read_data1, 32'h1);
`endif
        @(posedge clock);
        mdl[10] = 32'h2;
        #1;
        reg_write = 1'b0;
        #1;
        check("rdw_after_edge", read_data1, 32'h2);

        step(1'b1, 5'd29, 32'h0000_0040, 5'd29, 5'd0, "wr_r29");
        check("r29_written", read_data1, 32'h0000_0040);
        #2;
        reset_n = 1'b0;
        model_reset();
        reg_write = 1'b1;
        write_register = 5'd7;
        write_data = 32'h0000_0077;
        read_register1 = 5'd29;
        read_register2 = 5'd7;
        #1;
        check("async_r29", read_data1, SP_RST);
        @(posedge clock);
        #1 reset_n = 1'b1;
        reg_write = 1'b0;
        #1;
        check("release_edge_r7", read_data2, 32'h0);
        check("release_edge_r29", read_data1, SP_RST);
        @(posedge clock);
        #1;

        for (int n = 0; n < 300; n++) begin
            logic [4:0] wa;
            logic [4:0] r1;
            logic [4:0] r2;
            wa = 5'($urandom_range(0, 31));
            r1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            step(1'($urandom_range(0, 1)), wa, $urandom, r1, r2, "rand");
        end

        for (int a = 0; a < 32; a++) begin
            read_register1 = a[4:0];
            #1;
            check("final_scan", read_data1, expect_rd(a[4:0]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
